// File: rtl/jk_count_ctrl.sv
// J/K sequencing controller for a bank of JK cells forming a modulo-MOD up/down counter.
// Optional JKCNT_GRAY_OUT_EN adds a registered Gray-coded copy of the count (q_gray).
module jk_count_ctrl #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MOD   = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             en,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
`ifdef JKCNT_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  if ((MOD < 2) || (MOD > (1 << WIDTH))) begin : g_mod_check
    $error("jk_count_ctrl: MOD must lie in 2..2**WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] load_d;
  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] next_q;
  logic             do_count;
  logic             wrap;

  // Toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic acc_u, acc_d;
    up_t  = '0;
    dn_t  = '0;
    acc_u = 1'b1;
    acc_d = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      up_t[i] = acc_u;
      dn_t[i] = acc_d;
      acc_u   = acc_u & q[i];
      acc_d   = acc_d & ~q[i];
    end
  end

  always_comb begin
    load_d   = ({1'b0, load_val} >= MOD_W) ? MAX_Q : load_val;
    do_count = !load && !clr && (state == RUN) && en && !stop;
    wrap     = do_count && (up_dn ? (q == MAX_Q) : (q == '0));
  end

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (load) begin
      j_vec = load_d;
      k_vec = ~load_d;
    end else if (clr) begin
      j_vec = '0;
      k_vec = '1;
    end else if (do_count) begin
      if (up_dn) begin
        if (q == MAX_Q) begin
          j_vec = '0;
          k_vec = '1;
        end else begin
          j_vec = up_t;
          k_vec = up_t;
        end
      end else begin
        if (q == '0) begin
          j_vec = MAX_Q;
          k_vec = ~MAX_Q;
        end else begin
          j_vec = dn_t;
          k_vec = dn_t;
        end
      end
    end
  end

  // JK cell characteristic equation, evaluated bitwise across the bank.
  assign next_q = (j_vec & ~q) | (~k_vec & q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (stop)                 state_nxt = IDLE;
        else if (wrap && oneshot) state_nxt = DONE;
      end
      DONE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      tc    <= 1'b0;
      state <= IDLE;
    end else begin
      q     <= next_q;
      tc    <= wrap;
      state <= state_nxt;
    end
  end

`ifdef JKCNT_GRAY_OUT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) q_gray <= '0;
    else        q_gray <= next_q ^ (next_q >> 1);
  end
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Scoreboard bench for jk_count_ctrl (WIDTH=3, MOD=6): directed sequences then random stimulus.
// Checks q_gray as well when built with JKCNT_GRAY_OUT_EN.
module tb_jk_count_ctrl;
  localparam int W = 3;
  localparam int M = 6;
  localparam int MASK = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         up_dn = 1'b0, en = 1'b0, oneshot = 1'b0;
  logic [W-1:0] q, j_vec, k_vec;
  logic         tc, busy, done;
`ifdef JKCNT_GRAY_OUT_EN
  logic [W-1:0] q_gray;
`endif

  jk_count_ctrl #(.WIDTH(W), .MOD(M)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .load(load),
    .load_val(load_val), .up_dn(up_dn), .en(en), .oneshot(oneshot),
    .q(q), .tc(tc), .busy(busy), .done(done), .j_vec(j_vec), .k_vec(k_vec)
`ifdef JKCNT_GRAY_OUT_EN
    , .q_gray(q_gray)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int q;
    bit tc;
    bit busy;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: state 0=idle, 1=run, 2=done
  int m_st = 0;
  int m_q  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit r, input bit s, input bit sp, input bit c, input bit l,
                      input int lv, input bit ud, input bit e, input bit os);
    int  t, ej, ek;
    bit  cnt, wrap, forced;
    exp_t x;
    @(negedge CLK);
    start = s; stop = sp; clr = c; load = l; load_val = W'(lv);
    up_dn = ud; en = e; oneshot = os;
    if (r) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_q", 32'(q), 0);
      chk("rst_tc", 32'(tc), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      m_st = 0; m_q = 0;
      x = '{q: 0, tc: 0, busy: 0, done: 0};
      sb.push_back(x);
      return;
    end
    rst_n = 1'b1;
    cnt = 0; wrap = 0; forced = 0; t = m_q;
    if (l) begin
      t = (lv >= M) ? M - 1 : lv; forced = 1;
    end else if (c) begin
      t = 0; forced = 1;
    end else if (m_st == 1 && e && !sp) begin
      cnt  = 1;
      t    = ud ? (m_q + 1) % M : (m_q + M - 1) % M;
      wrap = ud ? (m_q == M - 1) : (m_q == 0);
      forced = wrap;
    end
    ej = forced ? t : (cnt ? (m_q ^ t) : 0);
    ek = forced ? (~t & MASK) : (cnt ? (m_q ^ t) : 0);
    #1;
    chk("j_vec", 32'(j_vec), 32'(ej));
    chk("k_vec", 32'(k_vec), 32'(ek));
    case (m_st)
      0: if (s) m_st = 1;
      1: if (sp) m_st = 0; else if (wrap && os) m_st = 2;
      default: if (sp) m_st = 0; else if (s) m_st = 1;
    endcase
    m_q = t;
    x = '{q: t, tc: wrap, busy: (m_st == 1), done: (m_st == 2)};
    sb.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("tc", 32'(tc), 32'(e.tc));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
`ifdef JKCNT_GRAY_OUT_EN
        chk("q_gray", 32'(q_gray), 32'(e.q ^ (e.q >> 1)));
`endif
      end
    end
  end

  initial begin
    //   r  s  sp c  l  lv ud e  os
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 0);                 // enter RUN, no count yet
    repeat (6) step(0, 0, 0, 0, 0, 0, 1, 1, 0);      // 1..5,0 with wrap tc
    repeat (2) step(0, 0, 0, 0, 0, 0, 1, 1, 0);      // to 2
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0);      // 1,0,5,4
    step(0, 0, 0, 0, 1, 7, 1, 1, 0);                 // clamped load -> 5
    step(0, 0, 0, 1, 1, 3, 1, 1, 0);                 // load beats clr -> 3
    step(0, 0, 1, 0, 0, 0, 1, 1, 0);                 // stop -> IDLE
    step(0, 1, 0, 0, 0, 0, 1, 1, 1);                 // start with oneshot
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 1, 1);      // 4,5,0 -> DONE
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, 1, 1);      // hold in DONE
    step(0, 1, 0, 0, 0, 0, 1, 1, 0);                 // resume RUN
    repeat (4) step(0, 0, 0, 0, 0, 0, 1, 1, 0);      // 1,2,3,4
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);                 // async reset mid-run
    step(0, 1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0, 0, 1, 1, 0);                 // stop+start in RUN -> IDLE
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 8,
           $urandom_range(99) < 5, $urandom_range(99) < 6, int'($urandom_range(MASK)),
           $urandom_range(1) == 1, $urandom_range(99) < 85, $urandom_range(99) < 30);
    end
    repeat (3) @(posedge CLK);
    #2;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_count_ctrl.md
Name: jk_count_ctrl

Overview:
Sequencing controller for a bank of WIDTH JK flip-flop cells, using the team's existing JK cell (async active-low reset, Q+ = J&~Q | ~K&Q). The block computes the J/K vectors each cycle to realise a modulo-MOD up/down counter with start/stop, synchronous load/clear and a one-shot mode. Used in the counter lab designs as the single place where counting is sequenced; the datapath state lives only in the JK cells.

Parameters:
WIDTH, 3, number of JK cells / counter bits
MOD, 8, count modulus; legal range 2..2**WIDTH; out-of-range is a static elaboration error

Ports:
CLK  in  1  clock, all state updates on rising edge
rst_n  in  1  reset
start  in  1  level; IDLE/DONE -> RUN
stop  in  1  level; RUN/DONE -> IDLE
clr  in  1  synchronous clear of count to 0
load  in  1  synchronous load of load_val
load_val  in  WIDTH  load value
up_dn  in  1  1 = count up, 0 = count down
en  in  1  count enable; acts only in RUN
oneshot  in  1  1 = stop in DONE after first wrap
q  out  WIDTH  counter value (JK cell Q outputs)
tc  out  1  registered one-cycle pulse on wrap
busy  out  1  state == RUN
done  out  1  state == DONE
j_vec  out  WIDTH  J inputs currently driven to the cells
k_vec  out  WIDTH  K inputs currently driven to the cells

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is CLK. While rst_n=0: q=0, state=IDLE, tc=0, busy=0, done=0. All cells and controller registers reset together.
- States: IDLE, RUN, DONE (2-bit encoded, busy/done decoded from state register).
- State transitions, evaluated per edge:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE. Wrap with oneshot=1 -> DONE.
  - DONE: stop -> IDLE, else start -> RUN.
  - stop has priority over start.
- Count action, priority order load > clr > count > hold:
  - load: per bit J=d, K=~d, with d = load_val, or MOD-1 if load_val >= MOD. Allowed in any state; state unchanged.
  - clr: J=0, K=1 on all bits. Allowed in any state.
  - count: requires state==RUN, en=1 and stop=0.
    - up: q==MOD-1 -> next 0 (J=0, K=1 on all bits); else standard toggle, J=K=AND of lower bits of q.
    - down: q==0 -> next MOD-1 (J=d, K=~d with d=MOD-1); else J=K=AND of inverted lower bits.
  - hold: J=K=0.
- j_vec/k_vec are combinational from q, state and inputs; the cells update on the same edge. Latency: one edge from request to new q.
- First count after start occurs on the edge following entry to RUN.
- tc: set to 1 on the edge performing a count-wrap (up MOD-1->0 or down 0->MOD-1); cleared on the next edge. Never set by load/clr.
- done asserts on the same edge as the final tc. q holds the wrapped value in DONE.
- Reset mid-count: immediate return to the reset state, no pending tc.
- en=0 in RUN: hold, no tc. up_dn may change every cycle and takes effect on the next edge.

Optional Feature:
Macro JKCNT_GRAY_OUT_EN.
- Defined: adds output q_gray [WIDTH-1:0], a registered value equal to next_q ^ (next_q>>1), updated on the same edge as q (cycle-aligned with q). Resets to 0.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- WIDTH=3, MOD=6; reset, start=1 one cycle, en=1, up_dn=1 -> q: 0,1,2,3,4,5,0; tc=1 only in the cycle q returns to 0; busy=1 throughout.
- Same config, up_dn=0 from q=2 -> q: 1,0,5,4; tc pulses once at 0->5.
- load=1 with load_val=7 while RUN -> q=5 next edge (clamped); simultaneous load and clr -> load wins.
- oneshot=1, start from q=3 counting up -> 4,5,0, then done=1, busy=0, q holds 0 for 5 idle cycles; start -> RUN, counting resumes 1,2.
- Assert rst_n=0 asynchronously mid-RUN at q=4 -> q=0, tc=0, busy=0 immediately, without a CLK edge; stop+start together in RUN -> IDLE.
- With JKCNT_GRAY_OUT_EN, WIDTH=3, MOD=8 full up sweep -> q_gray: 0,1,3,2,6,7,5,4,0, always matching q in the same cycle.
